// File: rtl/sinegen_dds.sv
// Multi-channel DDS waveform generator: per-channel phase accumulator, four
// waveforms, mid-scale-preserving attenuation and a registered sample output.
module sinegen_dds #(
    parameter int NCH   = 2,
    parameter int ACC_W = 16,
    parameter int DW    = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic                 i_sync,
    input  logic [NCH*ACC_W-1:0] i_step,
    input  logic [NCH*6-1:0]     i_phase,
    input  logic [NCH*2-1:0]     i_mode,
    input  logic [NCH*2-1:0]     i_scale,
    output logic [NCH*DW-1:0]    o_data,
    output logic                 o_valid
);

    typedef enum logic [1:0] {
        MODE_SINE   = 2'd0,
        MODE_SQUARE = 2'd1,
        MODE_SAW    = 2'd2,
        MODE_TRI    = 2'd3
    } mode_e;

    localparam logic [15:0]   MID      = 16'h8000;
    localparam logic [DW-1:0] DATA_RST = MID[15 -: DW];

    logic [NCH*ACC_W-1:0] acc_q,   acc_d;
    logic [NCH*DW-1:0]    data_q,  data_d;
    logic                 valid_q, valid_d;

    // Quarter-wave magnitude of the 90% sine; the other three quarters are mirrored.
    function automatic logic [14:0] quarter_sine(input logic [4:0] k);
        logic [14:0] mag;
        case (k)
            5'd0:    mag = 15'd0;
            5'd1:    mag = 15'd2891;
            5'd2:    mag = 15'd5753;
            5'd3:    mag = 15'd8561;
            5'd4:    mag = 15'd11286;
            5'd5:    mag = 15'd13902;
            5'd6:    mag = 15'd16384;
            5'd7:    mag = 15'd18709;
            5'd8:    mag = 15'd20853;
            5'd9:    mag = 15'd22797;
            5'd10:   mag = 15'd24521;
            5'd11:   mag = 15'd26009;
            5'd12:   mag = 15'd27246;
            5'd13:   mag = 15'd28221;
            5'd14:   mag = 15'd28925;
            5'd15:   mag = 15'd29349;
            5'd16:   mag = 15'd29491;
            default: mag = 15'd0;
        endcase
        return mag;
    endfunction

    function automatic logic [15:0] wave_sample(input logic [5:0] ptr, input logic [1:0] mode);
        logic [4:0]  k;
        logic [14:0] mag;
        logic [15:0] s;
        k   = (ptr[4:0] > 5'd16) ? 5'(6'd32 - {1'b0, ptr[4:0]}) : ptr[4:0];
        mag = quarter_sine(k);
        case (mode_e'(mode))
            MODE_SINE:   s = ptr[5] ? (MID - {1'b0, mag}) : (MID + {1'b0, mag});
            MODE_SQUARE: s = ptr[5] ? 16'h0CCD : 16'hF333;
            MODE_SAW:    s = {ptr, 10'b0};
            MODE_TRI:    s = ptr[5] ? {~ptr[4:0], 11'b0} : {ptr[4:0], 11'b0};
            default:     s = MID;
        endcase
        return s;
    endfunction

    // Shift in two's complement around mid-scale so attenuation keeps the DC level.
    function automatic logic [15:0] attenuate(input logic [15:0] s, input logic [1:0] scale);
        logic signed [15:0] d;
        d = signed'(s ^ MID);
        d = d >>> {scale, 1'b0};
        return unsigned'(d) ^ MID;
    endfunction

    always_comb begin
        logic [5:0]  ptr;
        logic [15:0] sample;
        acc_d   = acc_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ptr     = '0;
        sample  = '0;
        if (i_sync) begin
            acc_d = '0;
        end else if (i_en) begin
            valid_d = 1'b1;
            for (int k = 0; k < NCH; k++) begin
                ptr    = acc_q[k*ACC_W + ACC_W - 6 +: 6] + i_phase[k*6 +: 6];
                sample = attenuate(wave_sample(ptr, i_mode[k*2 +: 2]), i_scale[k*2 +: 2]);
                data_d[k*DW +: DW]       = sample[15 -: DW];
                acc_d[k*ACC_W +: ACC_W]  = acc_q[k*ACC_W +: ACC_W] + i_step[k*ACC_W +: ACC_W];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc_q   <= '0;
            data_q  <= {NCH{DATA_RST}};
            valid_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;

endmodule
